// File: rtl/ntt_share_scheduler.sv
// Round-robin scheduler sharing one NTT core among N_REQ polynomial requesters.
// The winner's polynomial is snapshotted, then the core is cleared, run and
// awaited; the result returns tagged with the owner id and a one-cycle done pulse.
//
//   state | meaning
//   IDLE  | core held in reset, arbitrating among requesters
//   CLEAR | core held in reset for RST_CYCLES cycles on the new snapshot
//   RUN   | core enabled, waiting for ntt_valid_i or the timeout
//   DONE  | done_o (and err_o on timeout) pulse, core back in reset
module ntt_share_scheduler #(
   parameter int N_REQ      = 3,
   parameter int COEFF_W    = 16,
   parameter int N_COEFF    = 256,
   parameter int RST_CYCLES = 2,
   parameter int TIMEOUT    = 4096
) (
   input  logic                             clk_i,
   input  logic                             reset_i,
   input  logic [N_REQ-1:0]                 req_i,
   input  logic [N_REQ*N_COEFF*COEFF_W-1:0] req_poly_i,
   output logic [N_REQ-1:0]                 gnt_o,
   output logic [N_REQ-1:0]                 done_o,
   output logic                             err_o,
   output logic                             busy_o,
   output logic [N_COEFF*COEFF_W-1:0]       result_o,
   output logic [$clog2(N_REQ)-1:0]         result_id_o,
   output logic                             ntt_enable_o,
   output logic                             ntt_reset_o,
   output logic [N_COEFF*COEFF_W-1:0]       ntt_in_o,
   input  logic [N_COEFF*COEFF_W-1:0]       ntt_out_i,
   input  logic                             ntt_valid_i
);

   localparam int ID_W  = $clog2(N_REQ);
   localparam int P     = N_COEFF * COEFF_W;
   localparam int CNT_W = $clog2(TIMEOUT);
   localparam int RC_W  = $clog2(RST_CYCLES + 1);

   typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_RUN, S_DONE} state_t;

   state_t           state_q, state_d;
   logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
   logic [ID_W-1:0]  owner_q, owner_d;
   logic [RC_W-1:0]  rst_cnt_q, rst_cnt_d;
   logic [CNT_W-1:0] run_cnt_q, run_cnt_d;
   logic [N_REQ-1:0] gnt_q, gnt_d;
   logic [N_REQ-1:0] done_q, done_d;
   logic             err_q, err_d;
   logic [P-1:0]     result_q, result_d;
   logic [ID_W-1:0]  result_id_q, result_id_d;
   logic             ntt_enable_q, ntt_enable_d;
   logic             ntt_reset_q, ntt_reset_d;
   logic [P-1:0]     ntt_in_q, ntt_in_d;

   logic             win_found;
   logic [ID_W-1:0]  win_id;
   logic [ID_W-1:0]  scan_id;

   // Round-robin pick: first active request scanning upward from rr_ptr_q.
   always_comb begin
      win_found = 1'b0;
      win_id    = '0;
      scan_id   = '0;
      for (int i = 0; i < N_REQ; i++) begin
         scan_id = ID_W'((int'(rr_ptr_q) + i) % N_REQ);
         if (!win_found && req_i[scan_id]) begin
            win_found = 1'b1;
            win_id    = scan_id;
         end
      end
   end

   // Next-state and registered-output logic; pulses default low every cycle.
   always_comb begin
      state_d      = state_q;
      rr_ptr_d     = rr_ptr_q;
      owner_d      = owner_q;
      rst_cnt_d    = rst_cnt_q;
      run_cnt_d    = run_cnt_q;
      gnt_d        = '0;
      done_d       = '0;
      err_d        = 1'b0;
      result_d     = result_q;
      result_id_d  = result_id_q;
      ntt_enable_d = ntt_enable_q;
      ntt_reset_d  = ntt_reset_q;
      ntt_in_d     = ntt_in_q;
      unique case (state_q)
         S_IDLE: begin
            ntt_reset_d  = 1'b1;
            ntt_enable_d = 1'b0;
            if (win_found) begin
               state_d         = S_CLEAR;
               gnt_d[win_id]   = 1'b1;
               ntt_in_d        = req_poly_i[int'(win_id)*P +: P];
               owner_d         = win_id;
               rr_ptr_d        = ID_W'((int'(win_id) + 1) % N_REQ);
               rst_cnt_d       = '0;
            end
         end
         S_CLEAR: begin
            if (rst_cnt_q == RC_W'(RST_CYCLES - 1)) begin
               state_d      = S_RUN;
               ntt_reset_d  = 1'b0;
               ntt_enable_d = 1'b1;
               run_cnt_d    = '0;
            end else begin
               rst_cnt_d = rst_cnt_q + 1'b1;
            end
         end
         S_RUN: begin
            if (ntt_valid_i) begin
               state_d         = S_DONE;
               result_d        = ntt_out_i;
               result_id_d     = owner_q;
               done_d[owner_q] = 1'b1;
               ntt_reset_d     = 1'b1;
               ntt_enable_d    = 1'b0;
            end else if (run_cnt_q == CNT_W'(TIMEOUT - 1)) begin
               // Timeout: result keeps its previous contents, only the id moves.
               state_d         = S_DONE;
               result_id_d     = owner_q;
               done_d[owner_q] = 1'b1;
               err_d           = 1'b1;
               ntt_reset_d     = 1'b1;
               ntt_enable_d    = 1'b0;
            end else begin
               run_cnt_d = run_cnt_q + 1'b1;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and output registers; reset aborts any job and parks the core in reset.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q      <= S_IDLE;
         rr_ptr_q     <= '0;
         owner_q      <= '0;
         rst_cnt_q    <= '0;
         run_cnt_q    <= '0;
         gnt_q        <= '0;
         done_q       <= '0;
         err_q        <= 1'b0;
         result_q     <= '0;
         result_id_q  <= '0;
         ntt_enable_q <= 1'b0;
         ntt_reset_q  <= 1'b1;
         ntt_in_q     <= '0;
      end else begin
         state_q      <= state_d;
         rr_ptr_q     <= rr_ptr_d;
         owner_q      <= owner_d;
         rst_cnt_q    <= rst_cnt_d;
         run_cnt_q    <= run_cnt_d;
         gnt_q        <= gnt_d;
         done_q       <= done_d;
         err_q        <= err_d;
         result_q     <= result_d;
         result_id_q  <= result_id_d;
         ntt_enable_q <= ntt_enable_d;
         ntt_reset_q  <= ntt_reset_d;
         ntt_in_q     <= ntt_in_d;
      end
   end

   assign gnt_o        = gnt_q;
   assign done_o       = done_q;
   assign err_o        = err_q;
   assign busy_o       = (state_q != S_IDLE);
   assign result_o     = result_q;
   assign result_id_o  = result_id_q;
   assign ntt_enable_o = ntt_enable_q;
   assign ntt_reset_o  = ntt_reset_q;
   assign ntt_in_o     = ntt_in_q;

endmodule

// File: tb/tb_ntt_share_scheduler.sv
// Scoreboard bench for ntt_share_scheduler with a stub NTT core.
// Stub core: output coeff = 3*in + 1, valid after LAT enabled cycles.
module tb_ntt_share_scheduler;

   localparam int N_REQ      = 3;
   localparam int COEFF_W    = 16;
   localparam int N_COEFF    = 8;
   localparam int RST_CYCLES = 2;
   localparam int TIMEOUT    = 64;
   localparam int ID_W       = 2;
   localparam int P          = N_COEFF * COEFF_W;
   localparam int LAT        = 10;

   typedef struct {
      int           id;
      logic         err;
      logic [P-1:0] res;
      logic [P-1:0] poly;
      int           cyc;
   } exp_t;

   logic                 clk = 1'b0;
   logic                 rst = 1'b1;
   logic [N_REQ-1:0]     req = '0;
   logic [N_REQ*P-1:0]   req_poly = '0;
   logic [N_REQ-1:0]     gnt, done;
   logic                 err, busy;
   logic [P-1:0]         result;
   logic [ID_W-1:0]      result_id;
   logic                 ntt_enable, ntt_reset;
   logic [P-1:0]         ntt_in, ntt_out;
   logic                 ntt_valid;

   logic                 stub_hang = 1'b0;
   logic                 inj_valid = 1'b0;
   int                   stub_cnt = 0;
   int                   cyc = 0;
   int                   n_checks = 0;
   int                   n_fail = 0;
   exp_t                 gq[$];
   exp_t                 dq[$];
   exp_t                 g, d;
   logic                 job_open = 1'b0;
   logic [P-1:0]         cur_poly = '0;

   ntt_share_scheduler #(
      .N_REQ(N_REQ), .COEFF_W(COEFF_W), .N_COEFF(N_COEFF),
      .RST_CYCLES(RST_CYCLES), .TIMEOUT(TIMEOUT)
   ) dut (
      .clk_i(clk), .reset_i(rst), .req_i(req), .req_poly_i(req_poly),
      .gnt_o(gnt), .done_o(done), .err_o(err), .busy_o(busy),
      .result_o(result), .result_id_o(result_id),
      .ntt_enable_o(ntt_enable), .ntt_reset_o(ntt_reset), .ntt_in_o(ntt_in),
      .ntt_out_i(ntt_out), .ntt_valid_i(ntt_valid)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   function automatic logic [P-1:0] core_f(input logic [P-1:0] x);
      logic [P-1:0] y;
      y = '0;
      for (int i = 0; i < N_COEFF; i++)
         y[i*COEFF_W +: COEFF_W] = x[i*COEFF_W +: COEFF_W] * 16'd3 + 16'd1;
      return y;
   endfunction

   function automatic logic [P-1:0] mk_poly(input logic [15:0] base, input logic [15:0] step);
      logic [P-1:0] y;
      y = '0;
      for (int i = 0; i < N_COEFF; i++)
         y[i*COEFF_W +: COEFF_W] = base + 16'(i) * step;
      return y;
   endfunction

   function automatic logic [N_REQ-1:0] onehot(input int id);
      logic [N_REQ-1:0] v;
      v = '0;
      v[id] = 1'b1;
      return v;
   endfunction

   // Stub core: counts enabled cycles since its last reset.
   always @(posedge clk) begin
      if (ntt_reset) stub_cnt <= 0;
      else if (ntt_enable) stub_cnt <= stub_cnt + 1;
   end

   assign ntt_valid = (!stub_hang && stub_cnt >= LAT) || inj_valid;
   assign ntt_out   = core_f(ntt_in);

   task automatic chk(input string name, input logic [P-1:0] act, input logic [P-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic push_job(input int id, input logic [P-1:0] poly, input int gcyc,
                           input logic has_done, input logic e, input logic [P-1:0] res,
                           input int dcyc);
      exp_t x;
      x.id = id; x.poly = poly; x.cyc = gcyc; x.err = e; x.res = res;
      gq.push_back(x);
      if (has_done) begin
         x.cyc = dcyc;
         dq.push_back(x);
      end
   endtask

   // Monitor: pops expectations whenever the DUT presents a grant or a done.
   always @(negedge clk) begin
      if (rst) begin
         job_open = 1'b0;
      end else begin
         if (gnt != '0) begin
            if (gq.size() == 0) begin
               n_checks++; n_fail++;
               $display("FAIL gnt_unexpected: got gnt=%b expected none", gnt);
            end else begin
               g = gq.pop_front();
               chk("gnt_id", P'(gnt), P'(onehot(g.id)));
               chk("gnt_cycle", P'(cyc), P'(g.cyc));
               chk("gnt_snapshot", ntt_in, g.poly);
               chk("gnt_busy", P'(busy), P'(1'b1));
               chk("gnt_no_overlap", P'(job_open), P'(1'b0));
               cur_poly = g.poly;
            end
            job_open = 1'b1;
         end
         if (done != '0) begin
            if (dq.size() == 0) begin
               n_checks++; n_fail++;
               $display("FAIL done_unexpected: got done=%b err=%b expected none", done, err);
            end else begin
               d = dq.pop_front();
               chk("done_id", P'(done), P'(onehot(d.id)));
               chk("done_err", P'(err), P'(d.err));
               chk("done_result_id", P'(result_id), P'(d.id));
               chk("done_result", result, d.res);
               chk("done_cycle", P'(cyc), P'(d.cyc));
               chk("done_ntt_in_stable", ntt_in, cur_poly);
               chk("done_core_parked", P'({ntt_reset, ntt_enable}), P'(2'b10));
            end
            job_open = 1'b0;
         end
         if (err && done == '0) begin
            n_checks++; n_fail++;
            $display("FAIL err_without_done: got err=1 done=%b expected err=0", done);
         end
      end
   end

   task automatic wait_gnt(input int budget, input string tag);
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (gnt == '0 && n < budget);
      if (gnt == '0) begin
         n_checks++; n_fail++;
         $display("FAIL %s_gnt_timeout: got no gnt in %0d cycles expected a gnt", tag, budget);
      end
   endtask

   task automatic wait_idle(input int budget, input string tag);
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while ((gq.size() != 0 || dq.size() != 0 || busy) && n < budget);
      if (gq.size() != 0 || dq.size() != 0 || busy) begin
         n_checks++; n_fail++;
         $display("FAIL %s_timeout: got %0d gnt / %0d done pending busy=%b expected all served",
                  tag, gq.size(), dq.size(), busy);
         gq.delete();
         dq.delete();
      end
   endtask

   initial begin
      logic [P-1:0] ramp, p0, p1, p2, p7;
      int c;
      ramp = mk_poly(16'h0000, 16'h0001);
      p0   = mk_poly(16'h0100, 16'h0001);
      p1   = mk_poly(16'h0200, 16'h0005);
      p2   = mk_poly(16'hFFFF, 16'hFFFF);
      p7   = mk_poly(16'h0007, 16'h0000);

      // Reset state
      repeat (2) @(negedge clk);
      chk("rst_gnt", P'(gnt), '0);
      chk("rst_done", P'(done), '0);
      chk("rst_err", P'(err), '0);
      chk("rst_busy", P'(busy), '0);
      chk("rst_enable", P'(ntt_enable), '0);
      chk("rst_ntt_reset", P'(ntt_reset), P'(1'b1));
      chk("rst_result", result, '0);
      chk("rst_result_id", P'(result_id), '0);
      chk("rst_ntt_in", ntt_in, '0);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // Single requester 1, ramp polynomial, latency 1+2+10+1
      req_poly[1*P +: P] = ramp;
      req = 3'b010;
      c = cyc;
      push_job(1, ramp, c + 1, 1'b1, 1'b0, core_f(ramp), c + 14);
      wait_gnt(10, "single");
      req = '0;
      wait_idle(100, "single");
      chk("single_coeff3", P'(result[3*COEFF_W +: COEFF_W]), P'(16'd10));
      chk("single_coeff7", P'(result[7*COEFF_W +: COEFF_W]), P'(16'd22));

      // Timeout on requester 2: err with done, result keeps previous value
      req_poly[2*P +: P] = p2;
      stub_hang = 1'b1;
      req = 3'b100;
      c = cyc;
      push_job(2, p2, c + 1, 1'b1, 1'b1, core_f(ramp), c + 1 + RST_CYCLES + TIMEOUT);
      wait_gnt(10, "timeout");
      req = '0;
      wait_idle(200, "timeout");
      stub_hang = 1'b0;

      // All requesting, rr_ptr back at 0: order 0,1,2,0; poly 0 changed after its grant
      req_poly[0*P +: P] = p0;
      req_poly[1*P +: P] = p1;
      req = 3'b111;
      c = cyc;
      push_job(0, p0, c + 1,  1'b1, 1'b0, core_f(p0), c + 14);
      push_job(1, p1, c + 16, 1'b1, 1'b0, core_f(p1), c + 29);
      push_job(2, p2, c + 31, 1'b1, 1'b0, core_f(p2), c + 44);
      push_job(0, p7, c + 46, 1'b1, 1'b0, core_f(p7), c + 59);
      wait_gnt(10, "rr0");
      req_poly[0*P +: P] = p7;
      for (int k = 0; k < 3; k++) wait_gnt(40, "rr");
      req = '0;
      wait_idle(100, "rr");

      // Reset during RUN: immediate abort, no done, rr_ptr cleared
      req_poly[1*P +: P] = p1;
      req = 3'b010;
      c = cyc;
      push_job(1, p1, c + 1, 1'b0, 1'b0, '0, 0);
      wait_gnt(10, "abort");
      req = '0;
      repeat (5) @(negedge clk);
      chk("abort_running", P'({ntt_reset, ntt_enable, busy}), P'(3'b011));
      rst = 1'b1;
      @(negedge clk);
      chk("abort_core", P'({ntt_reset, ntt_enable}), P'(2'b10));
      chk("abort_busy", P'(busy), '0);
      chk("abort_pulses", P'({done, err}), '0);
      chk("abort_result", result, '0);
      chk("abort_ntt_in", ntt_in, '0);
      @(negedge clk);
      chk("abort_pulses2", P'({gnt, done, err}), '0);
      rst = 1'b0;
      @(negedge clk);
      req = 3'b100;
      c = cyc;
      push_job(2, p2, c + 1, 1'b1, 1'b0, core_f(p2), c + 14);
      wait_gnt(10, "post_abort");
      req = '0;
      wait_idle(100, "post_abort");

      // ntt_valid pulsed in IDLE and CLEAR is ignored
      inj_valid = 1'b1;
      @(negedge clk);
      inj_valid = 1'b0;
      req_poly[0*P +: P] = p0;
      req = 3'b001;
      c = cyc;
      push_job(0, p0, c + 1, 1'b1, 1'b0, core_f(p0), c + 14);
      wait_gnt(10, "inj");
      req = '0;
      inj_valid = 1'b1;
      repeat (2) @(negedge clk);
      inj_valid = 1'b0;
      wait_idle(100, "inj");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
